// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter on the MEM-stage load/store bus.
// A program stores bytes into a small TX FIFO. A bit-serial FSM sends each one
// as 8N1, LSB first. The frame becomes 8E1/8O1 when UART_PARITY_EN is defined.
//
// Optional feature macro: UART_PARITY_EN
//   This macro adds a PARITY bit between DATA and STOP.
//   CTRL bit2 selects odd parity; when it is 0 the parity is even.
//
// Register map (word offset i_address):
//   0 TXDATA  W: push byte [7:0] (dropped and overflow set when full); R: 0
//   1 STATUS  R: {16'b0, count[7:0], 4'b0, overflow, busy, empty, full}
//             W: bit3 write-1-to-clear overflow
//   2 CTRL    RW: bit0 tx_en, bit1 irq_en, bit2 odd_parity (parity build only)
//   3 reserved (writes ignored, reads 0)
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_sel             peripheral window selected by MEM-stage decode
//   i_address         word offset within the peripheral
//   i_mem_write/read  store / load strobes
//   i_mem_write_data  store data
//   o_mem_read_data   combinational load data, 0 when not selected for a read
//   o_tx              registered serial line, idle high
//   o_irq             registered level interrupt: irq_en & empty & !busy
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_sel,
    input  logic [1:0]  i_address,
    input  logic        i_mem_write,
    input  logic        i_mem_read,
    input  logic [31:0] i_mem_write_data,
    output logic [31:0] o_mem_read_data,
    output logic        o_tx,
    output logic        o_irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            full, empty;
    logic            tx_en, irq_en, odd_parity, overflow;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shifter, shifter_next;
    logic            baud_done, pop, tx_d, busy;
    logic            wr, push_req, push;
    logic [31:0]     rdata;
    logic            unused_wdata;

    assign unused_wdata = ^i_mem_write_data[31:8];

    assign wr        = i_sel & i_mem_write;
    assign push_req  = wr & (i_address == 2'd0);
    // Acceptance looks at full from before the edge, so a pop on the same
    // edge does not make room for a push that arrives while the FIFO is full.
    assign push      = push_req & ~full;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    // ------------------------------------------------------------------ FIFO
    // NOTE: storage has no reset; it is never read before a push writes it, and
    // leaving it unreset lets synthesis map it to plain RAM or LUTRAM.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= i_mem_write_data[7:0];
    end

    // NOTE: all clocked state uses non-blocking assignments. Every register then
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------ control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_PARITY_EN
            odd_parity <= 1'b0;
`endif
        end else begin
            if (wr) begin
                case (i_address)
                    2'd1: if (i_mem_write_data[3]) overflow <= 1'b0;
                    2'd2: begin
                        tx_en  <= i_mem_write_data[0];
                        irq_en <= i_mem_write_data[1];
`ifdef UART_PARITY_EN
                        odd_parity <= i_mem_write_data[2];
`endif
                    end
                    default: ;
                endcase
            end
            if (push_req && full) overflow <= 1'b1;
        end
    end

`ifndef UART_PARITY_EN
    assign odd_parity = 1'b0;
`endif

    // ------------------------------------------------------------- TX FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: each combinational block assigns every output a default first, so
    // no path through it can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (tx_en && !empty) state_next = ST_START;
            ST_START:  if (baud_done) state_next = ST_DATA;
            ST_DATA:
                if (baud_done && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            ST_PARITY: if (baud_done) state_next = ST_STOP;
            ST_STOP:
                if (baud_done) state_next = (tx_en && !empty) ? ST_START : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic parity_bit;
`endif

    // The output stage looks ahead at state_next so that o_tx can be
    // registered and still change on the same edge as the state.
    always_comb begin
        pop          = (state_next == ST_START) && (state == ST_IDLE || state == ST_STOP);
        busy         = (state != ST_IDLE);
        shifter_next = shifter;
        tx_d         = 1'b1;
        if (pop)
            shifter_next = mem[rptr];
        else if (state == ST_DATA && baud_done)
            shifter_next = {1'b0, shifter[7:1]};
        case (state_next)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shifter_next[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = parity_bit;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter  <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            o_tx     <= 1'b1;
            o_irq    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            shifter  <= shifter_next;
            baud_cnt <= (state == ST_IDLE || baud_done) ? '0 : baud_cnt + BW'(1);
            if (state != ST_DATA)  bit_cnt <= '0;
            else if (baud_done)    bit_cnt <= bit_cnt + 3'd1;
            o_tx     <= tx_d;
            o_irq    <= irq_en & empty & ~busy;
`ifdef UART_PARITY_EN
            // The parity sense is latched when the byte is loaded, so a CTRL
            // write in the middle of a frame does not change that frame.
            if (pop) parity_bit <= (^mem[rptr]) ^ odd_parity;
`endif
        end
    end

    // ------------------------------------------------------------ read path
    always_comb begin
        rdata = '0;
        if (i_sel && i_mem_read) begin
            case (i_address)
                2'd1:    rdata = {16'b0, 8'(count), 4'b0, overflow, busy, empty, full};
                2'd2:    rdata = {29'b0, odd_parity, irq_en, tx_en};
                default: rdata = '0;
            endcase
        end
    end

    assign o_mem_read_data = rdata;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4
// and FIFO_DEPTH=8. A frame-level reference model holds a byte queue and
// tracks the cycle position inside the current frame. One compare process
// checks o_tx, o_irq and the load data against that model on every cycle.
// Directed sequences pin the model with hand-computed literal values. A
// randomized bus phase then exercises the remaining behaviour.
module tb_uart_tx_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FRAME_CYC = SLOTS * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_sel = 1'b0;
    logic [1:0]  i_address = 2'd0;
    logic        i_mem_write = 1'b0;
    logic        i_mem_read = 1'b0;
    logic [31:0] i_mem_write_data = '0;
    logic [31:0] o_mem_read_data;
    logic        o_tx;
    logic        o_irq;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_sel            (i_sel),
        .i_address        (i_address),
        .i_mem_write      (i_mem_write),
        .i_mem_read       (i_mem_read),
        .i_mem_write_data (i_mem_write_data),
        .o_mem_read_data  (o_mem_read_data),
        .o_tx             (o_tx),
        .o_irq            (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ----------------------------------------------------- reference model
    logic [7:0] q[$];
    int         fpos;          // cycles into the current frame, -1 when idle
    logic [7:0] fbyte;
    logic       fpar;
    logic       m_tx_en, m_irq_en, m_odd, m_ovf, m_irq;

    always @(posedge clk or negedge rst_n) begin : model_step
        logic was_full, was_empty, was_busy, do_pop;
        if (!rst_n) begin
            q.delete();
            fpos = -1; fbyte = '0; fpar = 1'b0;
            m_tx_en = 1'b0; m_irq_en = 1'b0; m_odd = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            was_busy  = (fpos >= 0);
            m_irq     = m_irq_en && was_empty && !was_busy;
            do_pop    = m_tx_en && !was_empty && (fpos < 0 || fpos == FRAME_CYC - 1);
            if (do_pop) begin
                fbyte = q.pop_front();
                fpar  = (^fbyte) ^ m_odd;
                fpos  = 0;
            end else if (fpos == FRAME_CYC - 1) fpos = -1;
            else if (fpos >= 0) fpos++;
            if (i_sel && i_mem_write) begin
                case (i_address)
                    2'd0: if (was_full) m_ovf = 1'b1; else q.push_back(i_mem_write_data[7:0]);
                    2'd1: if (i_mem_write_data[3]) m_ovf = 1'b0;
                    2'd2: begin
                        m_tx_en  = i_mem_write_data[0];
                        m_irq_en = i_mem_write_data[1];
`ifdef UART_PARITY_EN
                        m_odd    = i_mem_write_data[2];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (fpos < 0) return 1'b1;
        slot = fpos / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return fbyte[slot-1];
`ifdef UART_PARITY_EN
        if (slot == 9) return fpar;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!(i_sel && i_mem_read)) return '0;
        case (i_address)
            2'd1: return {16'b0, 8'(q.size()), 4'b0, m_ovf, (fpos >= 0),
                          (q.size() == 0), (q.size() == DEPTH)};
            2'd2: return {29'b0, m_odd, m_irq_en, m_tx_en};
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("o_tx", {31'b0, o_tx}, {31'b0, exp_tx()});
            check("o_irq", {31'b0, o_irq}, {31'b0, m_irq});
            check("read_data", o_mem_read_data, exp_rd());
        end
    end

    // ------------------------------------------------------------ bus tasks
    task automatic idle_bus();
        i_sel = 1'b0; i_mem_write = 1'b0; i_mem_read = 1'b0; i_address = 2'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        i_sel = 1'b1; i_mem_write = 1'b1; i_mem_read = 1'b0;
        i_address = a; i_mem_write_data = d;
        tick(1);
        idle_bus();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        i_sel = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_address = a;
        @(negedge clk);
        d = o_mem_read_data;
        tick(1);
        idle_bus();
    endtask

    // Push one byte, then hold a STATUS read. Count the busy cycles and sample
    // o_tx at the middle of each bit slot.
    task automatic send_and_watch(input logic [7:0] b, output int busy_cyc,
                                  output logic [10:0] slots);
        busy_cyc = 0;
        slots    = '0;
        bus_write(2'd0, {24'b0, b});
        i_sel = 1'b1; i_mem_read = 1'b1; i_address = 2'd1;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            if (o_mem_read_data[2]) busy_cyc++;
            if (i % CPB == 2 && i / CPB < 11) slots[i / CPB] = o_tx;
        end
        idle_bus();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        logic [10:0] slots;
        int busy_cyc, irq_at, low_cnt, bound;
        logic [7:0] msg [8];
        msg = '{8'h6C, 8'h69, 8'h6E, 8'h75, 8'h78, 8'h20, 8'h69, 8'h73};

        // Reset state
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("reset_o_tx", {31'b0, o_tx}, 32'd1);
        check("reset_o_irq", {31'b0, o_irq}, 32'd0);
        bus_read(2'd1, rd);
        check("reset_status", rd, 32'h0000_0002);

        // One frame of 'l'
        bus_write(2'd2, 32'h1);
        send_and_watch(8'h6C, busy_cyc, slots);
        check("frame_6c_slots", {21'b0, slots}, 32'h0000_06D8);
        check("frame_6c_busy", busy_cyc, 32'd40);

        // Fill the FIFO with the TX disabled, then overflow and clear
        bus_write(2'd2, 32'h0);
        foreach (msg[i]) bus_write(2'd0, {24'b0, msg[i]});
        bus_read(2'd1, rd);
        check("status_full", rd, 32'h0000_0801);
        bus_write(2'd0, 32'h21);
        bus_read(2'd1, rd);
        check("status_overflow", rd, 32'h0000_0809);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, rd);
        check("status_ovf_clear", rd, 32'h0000_0801);

        // Drain as back-to-back frames with the interrupt enabled
        bus_write(2'd2, 32'h3);
        i_sel = 1'b1; i_mem_read = 1'b1; i_address = 2'd1;
        busy_cyc = 0; irq_at = 0;
        for (int i = 1; i <= 400 && irq_at == 0; i++) begin
            tick(1);
            if (o_mem_read_data[2]) busy_cyc++;
            if (o_irq) irq_at = i;
        end
        idle_bus();
        check("drain_busy_cycles", busy_cyc, 32'd320);
        check("drain_irq_cycle", irq_at, 32'd322);

        // Reset in the middle of a frame
        bus_write(2'd2, 32'h0);
        repeat (3) bus_write(2'd0, 32'h00);
        bus_write(2'd2, 32'h1);
        tick(10);
        check("pre_reset_data_bit", {31'b0, o_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("reset_async_o_tx", {31'b0, o_tx}, 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        bus_read(2'd2, rd);
        check("post_reset_ctrl", rd, 32'h0);
        bus_read(2'd1, rd);
        check("post_reset_status", rd, 32'h0000_0002);
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (!o_tx) low_cnt++;
        end
        check("post_reset_line_idle", low_cnt, 32'd0);

        // Randomized bus traffic against the model
        for (int i = 0; i < 900; i++) begin
            int op;
            op = $urandom_range(0, 9);
            i_sel = ($urandom_range(0, 15) != 0);
            i_mem_write_data = $urandom;
            case (op)
                0, 1, 2: begin i_mem_write = 1'b1; i_address = 2'd0; end
                3: begin
                    i_mem_write = 1'b1; i_address = 2'd2;
                    i_mem_write_data[0] = ($urandom_range(0, 3) != 0);
                end
                4: begin i_mem_write = 1'b1; i_address = 2'd1; end
                5: begin i_mem_write = 1'b1; i_address = 2'd3; end
                6, 7: begin i_mem_read = 1'b1; i_address = 2'($urandom_range(0, 3)); end
                default: i_sel = 1'b0;
            endcase
            tick(1);
            idle_bus();
        end

        // Drain whatever is left
        bus_write(2'd2, 32'h3);
        bound = 0;
        while ((fpos >= 0 || q.size() != 0) && bound < 3000) begin
            tick(1);
            bound++;
        end
        check("random_drain_done", {31'b0, (fpos < 0 && q.size() == 0)}, 32'd1);
        tick(3);

`ifdef UART_PARITY_EN
        bus_write(2'd2, 32'h1);
        send_and_watch(8'h07, busy_cyc, slots);
        check("parity_even_slots", {21'b0, slots}, 32'h0000_060E);
        check("parity_frame_busy", busy_cyc, 32'd44);
        bus_write(2'd2, 32'h5);
        send_and_watch(8'h07, busy_cyc, slots);
        check("parity_odd_slots", {21'b0, slots}, 32'h0000_040E);
        bus_read(2'd2, rd);
        check("parity_ctrl_read", rd, 32'h5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
